// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// The producer/consumer side uses master; the adder uses slave.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide adder that streams operands LS nibble first through one 4-bit
// carry-lookahead slice, chaining the carry through a register.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W+1:0]   nib_lsb;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sum_q;
  logic               c;
  logic               cout_q;
  logic               ovf_q;
  logic [5:0]         slice;
  logic               last;

  // Returns {c3, c4, s[3:0]}; c3 is kept for the signed-overflow test.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] p;
    logic [3:0] g;
    logic       c1, c2, c3, c4;
    p  = x ^ y;
    g  = x & y;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c3, c4, p ^ {c3, c2, c1, ci}};
  endfunction

  assign nib_lsb = {idx, 2'b00};
  assign last    = (idx == IDX_W'(NIBBLES - 1));

  always_comb begin
    slice = cla4(a_q[nib_lsb +: 4], b_q[nib_lsb +: 4], c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = ADD;
      ADD:     if (last)          state_next = HOLD;
      HOLD:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Handshake flags decode the state register only, so they are glitch-free
  // and have no combinational path from in_valid or out_ready.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.busy      = (state == ADD);
    bus.out_valid = (state == HOLD);
  end

  // Operand registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      a_q <= bus.a;
      b_q <= bus.b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      c      <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            idx   <= '0;
            c     <= bus.cin;
            sum_q <= '0;
          end
        end
        ADD: begin
          sum_q[nib_lsb +: 4] <= slice[3:0];
          c                   <= slice[4];
          if (last) begin
            idx    <= '0;
            cout_q <= slice[4];
            ovf_q  <= slice[5] ^ slice[4];
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (NIBBLES=4): directed vectors push
// hand-computed results; a monitor pops them on each result handshake.
module tb_nibble_serial_adder;
  localparam int N = 4;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_adder_if #(.NIBBLES(N)) bus ();

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  // Result monitor: every handshake must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sum", bus.sum, e.sum);
        check("cout", bus.cout, e.cout);
        check("ovf", bus.ovf, e.ovf);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                        input bit push, input bit hold, input logic [15:0] es,
                        input logic ec, input logic eo, output int t0);
    int n = 0;
    bus.a = av;
    bus.b = bv;
    bus.cin = cv;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    if (!bus.in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    t0 = cyc;
    if (push) sb.push_back('{es, ec, eo});
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      step();
      n++;
    end
    check("out_valid_timeout", bus.out_valid, 1'b1);
  endtask

  initial begin
    int t0;
    int t[3];
    int n;
    logic [15:0] va[3];
    logic [15:0] vb[3];
    logic        vc[3];
    logic [15:0] vs[3];
    logic        vco[3];
    logic        vov[3];
    va = '{16'h8000, 16'hABCD, 16'hFFFF};
    vb = '{16'h8000, 16'h1111, 16'hFFFF};
    vc = '{1'b0, 1'b1, 1'b1};
    vs = '{16'h0000, 16'hBCDF, 16'hFFFF};
    vco = '{1'b1, 1'b0, 1'b1};
    vov = '{1'b1, 1'b0, 1'b0};

    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.out_ready = 1'b1;

    // Reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum", bus.sum, 16'h0000);
    check("rst_cout", bus.cout, 1'b0);
    check("rst_ovf", bus.ovf, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;
    step();

    // Full carry propagation with busy window and latency
    accept(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, t0);
    for (int i = 0; i < N; i++) begin
      check("busy_in_add", bus.busy, 1'b1);
      check("no_early_valid", bus.out_valid, 1'b0);
      check("in_ready_in_add", bus.in_ready, 1'b0);
      step();
    end
    check("latency_valid", bus.out_valid, 1'b1);
    check("busy_after_add", bus.busy, 1'b0);

    // Signed overflow, then carry-in
    accept(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, t0);
    wait_out();
    accept(16'h1234, 16'h4321, 1'b1, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, t0);
    wait_out();
    step();
    step();

    // Backpressure with an ignored in_valid pulse
    bus.out_ready = 1'b0;
    accept(16'h00F0, 16'h0F10, 1'b0, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, t0);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      check("bp_sum", bus.sum, 16'h1000);
      check("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_in_ready", bus.in_ready, 1'b0);
      if (i == 1) begin
        bus.in_valid = 1'b1;
        bus.a = 16'hAAAA;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    check("bp_release_out_valid", bus.out_valid, 1'b0);
    check("bp_release_in_ready", bus.in_ready, 1'b1);
    step();
    check("bp_pulse_ignored", bus.busy, 1'b0);

    // Reset in the middle of an addition
    accept(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, t0);
    step();
    rst_n = 1'b0;
    step();
    check("mid_rst_in_ready", bus.in_ready, 1'b1);
    check("mid_rst_sum", bus.sum, 16'h0000);
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    accept(16'h0003, 16'h0004, 1'b0, 1'b1, 1'b0, 16'h0007, 1'b0, 1'b0, t0);
    wait_out();
    check("post_rst_latency", cyc - t0, N);

    // Back-to-back with in_valid held high
    for (int i = 0; i < 3; i++)
      accept(va[i], vb[i], vc[i], 1'b1, 1'b1, vs[i], vco[i], vov[i], t[i]);
    bus.in_valid = 1'b0;
    check("b2b_spacing_1", t[1] - t[0], N + 2);
    check("b2b_spacing_2", t[2] - t[1], N + 2);
    wait_out();

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
